// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_DATA
    } state_t;

    localparam int unsigned CMD_READ_BIT = 7;
    localparam int unsigned ADDR_BITS    = 7;
    localparam logic [7:0]  TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register bus bridge: command byte, then write data or read data bytes.
// Define SPI_REG_BRIDGE_AUTOINC_EN to auto-increment addr after each data byte.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 255,
    parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_falling,
    input  logic [7:0]           rx_data,
    input  logic                 rx_data_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] addr,
    output logic [7:0]           wr_data,
    input  logic [7:0]           rd_data,
    input  logic                 rd_valid,
    output logic                 rd_timeout
);

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);

    state_t                state, state_next;
    logic [ADDR_BITS-1:0]  addr_next;
    logic [7:0]            wr_data_next, tx_data_next;
    logic                  wr_en_next, rd_en_next, tx_valid_next, rd_timeout_next;
    logic [CW-1:0]         tmo_cnt, tmo_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            wr_data       <= '0;
            tx_data       <= IDLE_BYTE;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            tx_data_valid <= 1'b0;
            rd_timeout    <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            state         <= state_next;
            addr          <= addr_next;
            wr_data       <= wr_data_next;
            tx_data       <= tx_data_next;
            wr_en         <= wr_en_next;
            rd_en         <= rd_en_next;
            tx_data_valid <= tx_valid_next;
            rd_timeout    <= rd_timeout_next;
            tmo_cnt       <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        addr_next       = addr;
        wr_data_next    = wr_data;
        tx_data_next    = tx_data;
        wr_en_next      = 1'b0;
        rd_en_next      = 1'b0;
        tx_valid_next   = 1'b0;
        rd_timeout_next = rd_timeout;
        tmo_cnt_next    = tmo_cnt;

        // Write address advances after the strobe cycle so wr_en sees the old addr.
        if (wr_en && AUTOINC)
            addr_next = addr + 7'd1;

        if (cs_falling) begin
            state_next      = CMD;
            rd_timeout_next = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                CMD: begin
                    if (rx_data_valid) begin
                        addr_next  = rx_data[ADDR_BITS-1:0];
                        state_next = rx_data[CMD_READ_BIT] ? RD_REQ : WRITE;
                    end
                end
                WRITE: begin
                    if (rx_data_valid) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = rx_data;
                    end
                end
                RD_REQ: begin
                    rd_en_next   = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_valid) begin
                        tx_data_next  = rd_data;
                        tx_valid_next = 1'b1;
                        state_next    = RD_DATA;
                    end else if (tmo_cnt == CW'(RD_TIMEOUT - 1)) begin
                        tx_data_next    = TIMEOUT_BYTE;
                        tx_valid_next   = 1'b1;
                        rd_timeout_next = 1'b1;
                        state_next      = RD_DATA;
                    end else begin
                        tmo_cnt_next = tmo_cnt + CW'(1);
                    end
                end
                RD_DATA: begin
                    if (rx_data_valid) begin
                        if (AUTOINC)
                            addr_next = addr + 7'd1;
                        state_next = RD_REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (!(state_next inside {RD_WAIT, RD_DATA}))
            tx_data_next = IDLE_BYTE;
    end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 255, giving the maximum clk cycles to wait for rd_valid after rd_en.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'h00, the tx byte presented while no read data is pending.
REQ-003 SHALL use a single clock clk; rst is synchronous and active-high.
REQ-004 clk  in  1  system clock, shared with the SPI slave transceiver.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cs_falling  in  1  one-cycle pulse marking the start of a SPI transaction.
REQ-007 rx_data  in  8  received byte, valid with rx_data_valid.
REQ-008 rx_data_valid  in  1  one-cycle pulse per received byte.
REQ-009 tx_data  out  8  next byte for the transceiver to shift out.
REQ-010 tx_data_valid  out  1  one-cycle pulse that loads tx_data into the transceiver.
REQ-011 wr_en  out  1  one-cycle register-write strobe.
REQ-012 rd_en  out  1  one-cycle register-read strobe.
REQ-013 addr  out  7  register address for wr_en/rd_en.
REQ-014 wr_data  out  8  write data, valid with wr_en.
REQ-015 rd_data  in  8  read data, valid with rd_valid.
REQ-016 rd_valid  in  1  one-cycle read completion, any latency >= 1 cycle after rd_en.
REQ-017 rd_timeout  out  1  sticky flag, set on a read timeout, cleared by rst or cs_falling.

Function
REQ-018 Protocol: the first byte after cs_falling is the command. Bit 7 set means read, clear means write. Bits 6:0 are the start address.
REQ-019 FSM states SHALL be IDLE, CMD, WRITE, RD_REQ, RD_WAIT, RD_DATA.
REQ-020 IDLE -> CMD on cs_falling. Every state SHALL go -> CMD on cs_falling, and cs_falling SHALL take priority over a same-cycle rx_data_valid or rd_valid.
REQ-021 CMD + rx_data_valid: latch addr = rx_data[6:0]. Go -> WRITE if bit7 = 0, else -> RD_REQ.
REQ-022 WRITE + rx_data_valid: drive wr_en = 1 and wr_data = rx_data on the next cycle at the current addr, then advance addr per REQ-031.
REQ-023 RD_REQ: assert rd_en for exactly one cycle at the current addr, then -> RD_WAIT and clear the timeout counter.
REQ-024 RD_WAIT + rd_valid: tx_data <= rd_data and pulse tx_data_valid the next cycle, then -> RD_DATA.
REQ-025 RD_WAIT timeout: after RD_TIMEOUT cycles without rd_valid, tx_data <= 8'hFF, pulse tx_data_valid, set rd_timeout, then -> RD_DATA.
REQ-026 RD_DATA + rx_data_valid (dummy byte clocked out): advance addr per REQ-031, then -> RD_REQ.
REQ-027 A rd_valid arriving outside RD_WAIT, including after an abort by cs_falling, SHALL be ignored.
REQ-028 Whenever not in RD_WAIT/RD_DATA, tx_data SHALL equal IDLE_BYTE, so the transceiver loads IDLE_BYTE at cs_falling.
REQ-029 The cs_falling-to-first-byte path SHALL drive no bus strobes. wr_en and rd_en SHALL never be high in the same cycle.
REQ-030 Read turnaround: cycles from rx_data_valid to tx_data_valid SHALL be 3 + bus latency. The master must leave enough inter-byte gap to cover this.
REQ-031 Address arithmetic SHALL be 7-bit modulo: 7'h7F + 1 = 7'h00.

Reset
REQ-032 On rst: state = IDLE; addr = 0; wr_data = 0; tx_data = IDLE_BYTE; wr_en, rd_en, tx_data_valid and rd_timeout = 0; timeout counter = 0.
REQ-033 rst mid-transaction SHALL abandon the transaction. Subsequent bytes are ignored until the next cs_falling.

Configuration
REQ-034 With SPI_REG_BRIDGE_AUTOINC_EN defined, addr SHALL increment after each write and each read data byte.
REQ-035 Without SPI_REG_BRIDGE_AUTOINC_EN, addr SHALL stay fixed at the command address for the whole transaction (FIFO-style access).

Structure
REQ-036 Shared package spi_reg_bridge_pkg SHALL hold the FSM state enum, CMD_READ_BIT = 7, ADDR_BITS = 7 and TIMEOUT_BYTE = 8'hFF.
REQ-037 One sub-module is natural: none is required. The FSM, address counter and timeout counter SHALL be inline in one module.

Verification
REQ-038 Write 8'h05, 8'hAA, 8'h55 with AUTOINC -> wr_en at addr 5 with data AA, then at addr 6 with data 55. No rd_en.
REQ-039 Read 8'h90 with rd_data = 8'h3C at latency 2, then a dummy byte -> rd_en at addr 0x10, tx_data_valid with 3C, then rd_en at addr 0x11.
REQ-040 Write 8'h7F, 8'h01, 8'h02 with AUTOINC -> writes at addr 7F then 00 (wraparound).
REQ-041 Read with rd_valid never asserted and RD_TIMEOUT = 4 -> tx_data_valid with FF after 4 cycles, rd_timeout = 1, then rd_timeout = 0 after the next cs_falling.
REQ-042 cs_falling in the same cycle as rx_data_valid during WRITE -> no wr_en; the byte after it is parsed as a command.
REQ-043 rst asserted in RD_WAIT, then a late rd_valid -> no tx_data_valid, and outputs hold their reset values.
